// File: rtl/pipe_ctrl_if.sv
// Bundle of decode/execute/memory status seen by the pipeline controller and
// the stage control lines it drives back into the core.
interface pipe_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_ctrl;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  ex_valid;
  logic                  ex_ctrl;
  logic                  ex_pc_jump;
  logic [XLEN-1:0]       ex_pc_jump_addr;
  logic                  ex_unpause;
  logic                  ex_flush;
  logic                  ex_mem_load_en;
  logic [REG_ADDR_W-1:0] ex_mem_load_regs_addr;
  logic [1:0]            ex_mem_store_mode;
  logic                  mem_ready;

  logic                  pc_jump;
  logic [XLEN-1:0]       pc_jump_addr;
  logic                  pause_pc;
  logic                  pause_if_id;
  logic                  pause_id_ex;
  logic                  bubble_id_ex;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  mem_timeout_err;
  logic [1:0]            state;

  // Status/control lines are level signals sampled every cycle; there is no
  // valid/ready handshake on this bundle, ex_valid qualifies every EX field.
  modport master (
    output id_ctrl, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_ctrl, ex_pc_jump, ex_pc_jump_addr, ex_unpause,
           ex_flush, ex_mem_load_en, ex_mem_load_regs_addr,
           ex_mem_store_mode, mem_ready,
    input  pc_jump, pc_jump_addr, pause_pc, pause_if_id, pause_id_ex,
           bubble_id_ex, flush_if_id, flush_id_ex, mem_timeout_err, state
  );

  modport slave (
    input  id_ctrl, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_ctrl, ex_pc_jump, ex_pc_jump_addr, ex_unpause,
           ex_flush, ex_mem_load_en, ex_mem_load_regs_addr,
           ex_mem_store_mode, mem_ready,
    output pc_jump, pc_jump_addr, pause_pc, pause_if_id, pause_id_ex,
           bubble_id_ex, flush_if_id, flush_id_ex, mem_timeout_err, state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: resolves control, load-use and memory-wait
// hazards for the 5-stage core with one small FSM and combinational controls.
module pipe_ctrl #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    JWAIT = 2'd1,
    MWAIT = 2'd2,
    LUSE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic ex_fire, ex_mem, luse, flush, mem_stall;
  logic in_run, in_jwait, run_mwait, run_luse, jw_mwait, mw_hold;
  logic raw_pause_if_id, raw_pause_id_ex, raw_pause_pc, raw_flush_if_id;

  assign ex_fire   = bus.ex_valid & bus.ex_pc_jump;
  assign ex_mem    = bus.ex_valid & (bus.ex_mem_load_en | (bus.ex_mem_store_mode != 2'b00));
  assign mem_stall = ex_mem & ~bus.mem_ready;
  assign flush     = bus.ex_valid & (bus.ex_flush | bus.ex_pc_jump);
  assign luse      = bus.ex_valid & bus.ex_mem_load_en
                   & (bus.ex_mem_load_regs_addr != '0)
                   & ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_mem_load_regs_addr))
                    | (bus.id_rs2_used & (bus.id_rs2 == bus.ex_mem_load_regs_addr)));

  // LUSE spends its stall at detection, so it behaves exactly like RUN.
  assign in_run    = (state_q == RUN) | (state_q == LUSE);
  assign in_jwait  = (state_q == JWAIT);
  assign run_mwait = in_run & ~flush & mem_stall;
  assign run_luse  = in_run & ~flush & ~mem_stall & luse;
  assign jw_mwait  = in_jwait & mem_stall;
  assign mw_hold   = (state_q == MWAIT) & ~bus.mem_ready & (cnt_q != CNT_MAX);

  assign raw_pause_pc    = run_mwait | run_luse | in_jwait | mw_hold;
  assign raw_pause_if_id = run_mwait | run_luse | jw_mwait | mw_hold;
  assign raw_pause_id_ex = run_mwait | jw_mwait | mw_hold;
  assign raw_flush_if_id = flush | in_jwait;

  // Outputs are forced low while rst is high; a flush beats pause/bubble.
  assign bus.pc_jump         = ~rst & ex_fire;
  assign bus.pc_jump_addr    = (~rst & ex_fire) ? bus.ex_pc_jump_addr : '0;
  assign bus.flush_if_id     = ~rst & raw_flush_if_id;
  assign bus.flush_id_ex     = ~rst & flush;
  assign bus.pause_pc        = ~rst & raw_pause_pc;
  assign bus.pause_if_id     = ~rst & raw_pause_if_id & ~raw_flush_if_id;
  assign bus.pause_id_ex     = ~rst & raw_pause_id_ex & ~flush;
  assign bus.bubble_id_ex    = ~rst & run_luse & ~flush;
  assign bus.mem_timeout_err = err_q;
  assign bus.state           = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN, LUSE: begin
          if (flush) begin
            state_q <= RUN;
          end else if (mem_stall) begin
            state_q <= MWAIT;
            cnt_q   <= CNT_W'(1);
          end else if (luse) begin
            state_q <= LUSE;
          end else if (bus.id_ctrl) begin
            state_q <= JWAIT;
          end else begin
            state_q <= RUN;
          end
        end
        JWAIT: begin
          if (mem_stall) begin
            state_q <= MWAIT;
            cnt_q   <= CNT_W'(1);
          end else if (bus.ex_valid & (bus.ex_ctrl | bus.ex_unpause)) begin
            state_q <= RUN;
          end
        end
        MWAIT: begin
          if (bus.mem_ready) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued as each
// step is driven and popped when the combinational outputs are sampled.
module tb_pipe_ctrl;
  localparam int MT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  pipe_ctrl #(.XLEN(32), .REG_ADDR_W(5), .MEM_TIMEOUT(MT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [9:0]  exp_q[$];
  logic [31:0] addr_q[$];
  int total = 0;
  int bad   = 0;

  // {pc_jump, pause_pc, pause_if_id, pause_id_ex, bubble, flush_if_id, flush_id_ex, err, state}
  function automatic logic [9:0] ev(bit pj, bit ppc, bit pif, bit pide, bit bub,
                                    bit fif, bit fide, bit err, logic [1:0] st);
    return {pj, ppc, pif, pide, bub, fif, fide, err, st};
  endfunction

  task automatic clr();
    bus.id_ctrl = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.ex_valid = 0; bus.ex_ctrl = 0; bus.ex_pc_jump = 0;
    bus.ex_pc_jump_addr = 0; bus.ex_unpause = 0; bus.ex_flush = 0;
    bus.ex_mem_load_en = 0; bus.ex_mem_load_regs_addr = 0;
    bus.ex_mem_store_mode = 0; bus.mem_ready = 0;
  endtask

  task automatic step(input string tag, input logic [9:0] e, input logic [31:0] ea);
    logic [9:0]  obs, ex;
    logic [31:0] oa, xa;
    exp_q.push_back(e);
    addr_q.push_back(ea);
    #1;
    obs = {bus.pc_jump, bus.pause_pc, bus.pause_if_id, bus.pause_id_ex, bus.bubble_id_ex,
           bus.flush_if_id, bus.flush_id_ex, bus.mem_timeout_err, bus.state};
    oa  = bus.pc_jump_addr;
    ex  = exp_q.pop_front();
    xa  = addr_q.pop_front();
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, ex);
    end
    total++;
    assert (oa === xa) else begin
      bad++;
      $error("FAIL %s_addr observed=%h expected=%h", tag, oa, xa);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic store_wait();
    bus.ex_valid = 1; bus.ex_mem_store_mode = 2'b11; bus.mem_ready = 0;
  endtask

  initial begin
    logic [4:0] rd, rs;
    bit stall;
    clr();
    step("reset", ev(0,0,0,0,0,0,0,0,0), 0);
    next(); rst = 0;

    // Jump with flush while ID also holds a control instruction.
    bus.ex_valid = 1; bus.ex_ctrl = 1; bus.ex_pc_jump = 1; bus.ex_flush = 1;
    bus.ex_pc_jump_addr = 32'h0000_0100; bus.id_ctrl = 1;
    step("jal_flush", ev(1,0,0,0,0,1,1,0,0), 32'h100);
    next(); clr();
    step("jal_after", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    bus.ex_valid = 1; bus.ex_mem_load_en = 1; bus.ex_mem_load_regs_addr = 5;
    bus.mem_ready = 1; bus.id_rs1 = 5; bus.id_rs1_used = 1; bus.id_rs2 = 1; bus.id_rs2_used = 1;
    step("luse_det", ev(0,1,1,0,1,0,0,0,0), 0);
    next(); clr();
    step("luse_state", ev(0,0,0,0,0,0,0,0,3), 0);
    next();
    step("luse_back", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Same with rd = x0: no hazard.
    bus.ex_valid = 1; bus.ex_mem_load_en = 1; bus.ex_mem_load_regs_addr = 0;
    bus.mem_ready = 1; bus.id_rs1 = 0; bus.id_rs1_used = 1;
    step("luse_x0", ev(0,0,0,0,0,0,0,0,0), 0);
    next(); clr();
    step("luse_x0_next", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Word store, memory slow for the detect cycle plus three more.
    store_wait();
    step("st_det", ev(0,1,1,1,0,0,0,0,0), 0);
    for (int i = 0; i < 3; i++) begin
      next();
      step("st_wait", ev(0,1,1,1,0,0,0,0,2), 0);
    end
    next(); bus.mem_ready = 1;
    step("st_ready", ev(0,0,0,0,0,0,0,0,2), 0);
    next(); clr();
    step("st_done", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Memory never answers: timeout after MT paused cycles.
    store_wait();
    step("to_det", ev(0,1,1,1,0,0,0,0,0), 0);
    for (int i = 1; i < MT; i++) begin
      next();
      step("to_wait", ev(0,1,1,1,0,0,0,0,2), 0);
    end
    next();
    step("to_limit", ev(0,0,0,0,0,0,0,0,2), 0);
    next(); clr();
    step("to_err", ev(0,0,0,0,0,0,0,1,0), 0);
    next();
    step("to_sticky", ev(0,0,0,0,0,0,0,1,0), 0);
    next();

    // Reset in the middle of a memory wait (counter at 5).
    store_wait();
    step("rm_det", ev(0,1,1,1,0,0,0,1,0), 0);
    for (int i = 0; i < 4; i++) begin
      next();
      step("rm_wait", ev(0,1,1,1,0,0,0,1,2), 0);
    end
    next();
    step("rm_cnt5", ev(0,1,1,1,0,0,0,1,2), 0);
    rst = 1;
    step("rm_rst", ev(0,0,0,0,0,0,0,0,0), 0);
    next(); clr(); rst = 0;
    step("rm_after", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Branch not taken.
    bus.id_ctrl = 1;
    step("bnt_id", ev(0,0,0,0,0,0,0,0,0), 0);
    next(); clr();
    step("bnt_jwait", ev(0,1,0,0,0,1,0,0,1), 0);
    next(); bus.ex_valid = 1; bus.ex_ctrl = 1;
    step("bnt_ex", ev(0,1,0,0,0,1,0,0,1), 0);
    next(); clr();
    step("bnt_run", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Branch taken.
    bus.id_ctrl = 1;
    step("bt_id", ev(0,0,0,0,0,0,0,0,0), 0);
    next(); clr();
    step("bt_jwait", ev(0,1,0,0,0,1,0,0,1), 0);
    next();
    bus.ex_valid = 1; bus.ex_ctrl = 1; bus.ex_pc_jump = 1; bus.ex_pc_jump_addr = 32'h2000_0040;
    step("bt_ex", ev(1,1,0,0,0,1,1,0,1), 32'h2000_0040);
    next(); clr();
    step("bt_run", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Memory stall while waiting on a branch: memory wins.
    bus.id_ctrl = 1;
    step("jm_id", ev(0,0,0,0,0,0,0,0,0), 0);
    next(); clr();
    bus.ex_valid = 1; bus.ex_mem_load_en = 1; bus.ex_mem_load_regs_addr = 7;
    step("jm_stall", ev(0,1,0,1,0,1,0,0,1), 0);
    next(); bus.mem_ready = 1;
    step("jm_mwait", ev(0,0,0,0,0,0,0,0,2), 0);
    next(); clr();
    step("jm_run", ev(0,0,0,0,0,0,0,0,0), 0);
    next();

    // Random register pairs for load-use detection.
    for (int i = 0; i < 6; i++) begin
      rd = 5'($urandom_range(1, 31));
      rs = (i % 2 == 1) ? rd : 5'($urandom_range(0, 31));
      stall = (rs == rd);
      bus.ex_valid = 1; bus.ex_mem_load_en = 1; bus.ex_mem_load_regs_addr = rd;
      bus.mem_ready = 1; bus.id_rs1 = rs; bus.id_rs1_used = 1;
      step("rnd_det", ev(0,stall,stall,0,stall,0,0,0,0), 0);
      next(); clr();
      step("rnd_state", ev(0,0,0,0,0,0,0,0,stall ? 2'd3 : 2'd0), 0);
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
